bombe_rotor_search: RTL and testbench

//  Rotor-position search engine for the Bombe deduction stage. While enabled by the

---
 rtl/bombe_rotor_search_pkg.sv | 30 +++
 rtl/bombe_rotor_search_if.sv | 35 +++
 rtl/bombe_rotor_search_odometer.sv | 63 ++++++
 rtl/bombe_rotor_search.sv | 147 ++++++++++++++
 tb/tb_bombe_rotor_search.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/bombe_rotor_search_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bombe_pkg
// Description : Shared constants and FSM encoding for the Bombe rotor-position
//               search engine: default rotor geometry, last-position value
//               and the search state type.
// Revision    : 1.0 - initial release
// ============================================================================
package bombe_pkg;

    localparam int DEFAULT_NUM_LETTERS = 26;
    localparam int DEFAULT_POS_W       = 5;
    localparam int LAST_POS            = DEFAULT_NUM_LETTERS - 1;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_ISSUE   = 3'd1;
    localparam logic [2:0] ENC_WAIT    = 3'd2;
    localparam logic [2:0] ENC_FOUND   = 3'd3;
    localparam logic [2:0] ENC_EXHAUST = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_ISSUE   = ENC_ISSUE,
        ST_WAIT    = ENC_WAIT,
        ST_FOUND   = ENC_FOUND,
        ST_EXHAUST = ENC_EXHAUST
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bombe_rotor_search_if.sv
`default_nettype none
// ============================================================================
// Module      : bombe_rotor_search_if
// Description : Candidate/verdict link between the rotor search engine and the
//               Enigma evaluation core.
//   cand_valid/cand_ready  : candidate handshake
//   cand_r0/r1/r2          : fast/middle/slow rotor positions
//   result_valid/match     : verdict returned by the evaluation core
//   modport master : search engine side; modport slave : evaluation core side
// Revision    : 1.0 - initial release
// ============================================================================
interface bombe_rotor_search_if
    import bombe_pkg::*;
#(
    parameter int POS_W = DEFAULT_POS_W
);
    logic             cand_valid;
    logic             cand_ready;
    logic [POS_W-1:0] cand_r0;
    logic [POS_W-1:0] cand_r1;
    logic [POS_W-1:0] cand_r2;
    logic             result_valid;
    logic             result_match;

    modport master (
        output cand_valid, cand_r0, cand_r1, cand_r2,
        input  cand_ready, result_valid, result_match
    );

    modport slave (
        input  cand_valid, cand_r0, cand_r1, cand_r2,
        output cand_ready, result_valid, result_match
    );
endinterface
`default_nettype wire

// File: rtl/bombe_rotor_search_odometer.sv
`default_nettype none
// ============================================================================
// Module      : bombe_rotor_odometer
// Description : Three wrap-around rotor position counters chained by carry.
//   clk, reset (sync, active-low), clear (sync zero), inc (advance one step)
//   r0/r1/r2 : fast/middle/slow positions, each in 0..NUM_LETTERS-1
//   is_last  : all three positions at NUM_LETTERS-1
// Revision    : 1.0 - initial release
// ============================================================================
module bombe_rotor_odometer
    import bombe_pkg::*;
#(
    parameter int NUM_LETTERS = DEFAULT_NUM_LETTERS,
    parameter int POS_W       = DEFAULT_POS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [POS_W-1:0] r0,
    output logic [POS_W-1:0] r1,
    output logic [POS_W-1:0] r2,
    output logic             is_last
);

    localparam logic [POS_W-1:0] c_LAST = POS_W'(NUM_LETTERS - 1);
    localparam logic [POS_W-1:0] c_ONE  = POS_W'(1);

    logic [POS_W-1:0] r_pos0;
    logic [POS_W-1:0] r_pos1;
    logic [POS_W-1:0] r_pos2;
    logic             w_wrap0;
    logic             w_wrap1;
    logic             w_wrap2;

    assign w_wrap0 = (r_pos0 == c_LAST);
    assign w_wrap1 = (r_pos1 == c_LAST);
    assign w_wrap2 = (r_pos2 == c_LAST);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_pos0 <= '0;
            r_pos1 <= '0;
            r_pos2 <= '0;
        end else if (inc) begin
            r_pos0 <= w_wrap0 ? '0 : r_pos0 + c_ONE;
            // Carry ripples only when the faster rotor wraps.
            if (w_wrap0) begin
                r_pos1 <= w_wrap1 ? '0 : r_pos1 + c_ONE;
                if (w_wrap1) begin
                    r_pos2 <= w_wrap2 ? '0 : r_pos2 + c_ONE;
                end
            end
        end
    end

    assign r0      = r_pos0;
    assign r1      = r_pos1;
    assign r2      = r_pos2;
    assign is_last = w_wrap0 && w_wrap1 && w_wrap2;

endmodule
`default_nettype wire

// File: rtl/bombe_rotor_search.sv
`default_nettype none
// ============================================================================
// Module      : bombe_rotor_search
// Description : Walks all NUM_LETTERS^3 rotor start positions, issues each to
//               the evaluation core and stops on the first match or after the
//               last position.
//   clk, reset (sync, active-low), start (level enable, drop = abort)
//   cand_if (master) : candidate handshake + verdict
//   done = found | exhausted, found (position held), exhausted (no match)
//   Optional macro BOMBE_SEARCH_COUNT_EN adds tried_cnt[14:0], the number of
//   verdicts consumed in the current search.
// Revision    : 1.0 - initial release
// ============================================================================
module bombe_rotor_search
    import bombe_pkg::*;
#(
    parameter int NUM_LETTERS = DEFAULT_NUM_LETTERS,
    parameter int POS_W       = DEFAULT_POS_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    bombe_rotor_search_if.master cand_if,
    output logic                 done,
    output logic                 found,
    output logic                 exhausted
`ifdef BOMBE_SEARCH_COUNT_EN
    ,
    output logic [14:0]          tried_cnt
`endif
);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_inc;
    logic             w_clear;
    logic             w_is_last;
    logic             r_cand_valid;
    logic             r_found;
    logic             r_exhausted;
    logic             r_done;
    logic [POS_W-1:0] w_r0;
    logic [POS_W-1:0] w_r1;
    logic [POS_W-1:0] w_r2;

    bombe_rotor_odometer #(
        .NUM_LETTERS (NUM_LETTERS),
        .POS_W       (POS_W)
    ) u_odometer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .inc     (w_inc),
        .r0      (w_r0),
        .r1      (w_r1),
        .r2      (w_r2),
        .is_last (w_is_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Abort (start low) is tested first so it wins over handshake/verdict.
    always_comb begin
        w_state_next = r_state;
        w_inc        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!start)                  w_state_next = ST_IDLE;
                else if (cand_if.cand_ready) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!start) begin
                    w_state_next = ST_IDLE;
                end else if (cand_if.result_valid) begin
                    if (cand_if.result_match) begin
                        w_state_next = ST_FOUND;
                    end else if (w_is_last) begin
                        w_state_next = ST_EXHAUST;
                    end else begin
                        w_inc        = 1'b1;
                        w_state_next = ST_ISSUE;
                    end
                end
            end
            ST_FOUND, ST_EXHAUST: begin
                if (!start) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Positions read zero in IDLE and EXHAUST; a FOUND position is kept.
    assign w_clear = (w_state_next == ST_IDLE) || (w_state_next == ST_EXHAUST);

    // Flags are registered from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cand_valid <= 1'b0;
            r_found      <= 1'b0;
            r_exhausted  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_cand_valid <= (w_state_next == ST_ISSUE);
            r_found      <= (w_state_next == ST_FOUND);
            r_exhausted  <= (w_state_next == ST_EXHAUST);
            r_done       <= (w_state_next == ST_FOUND) || (w_state_next == ST_EXHAUST);
        end
    end

    assign cand_if.cand_valid = r_cand_valid;
    assign cand_if.cand_r0    = w_r0;
    assign cand_if.cand_r1    = w_r1;
    assign cand_if.cand_r2    = w_r2;
    assign found              = r_found;
    assign exhausted          = r_exhausted;
    assign done               = r_done;

`ifdef BOMBE_SEARCH_COUNT_EN
    logic        w_accept;
    logic [14:0] r_tried_cnt;

    assign w_accept = (r_state == ST_WAIT) && start && cand_if.result_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tried_cnt <= '0;
        end else if (w_state_next == ST_IDLE) begin
            r_tried_cnt <= '0;
        end else if (w_accept) begin
            r_tried_cnt <= r_tried_cnt + 15'd1;
        end
    end

    assign tried_cnt = r_tried_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bombe_rotor_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_bombe_rotor_search
// Description : Self-checking bench for bombe_rotor_search: a per-cycle vector
//               table for reset/match/abort, then directed sequences for
//               backpressure, carry propagation and full exhaustion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bombe_rotor_search;

    logic clk;
    logic reset;
    logic start;
    logic done;
    logic found;
    logic exhausted;
`ifdef BOMBE_SEARCH_COUNT_EN
    logic [14:0] tried_cnt;
`endif

    bombe_rotor_search_if #(.POS_W(5)) bus ();

    bombe_rotor_search #(
        .NUM_LETTERS (26),
        .POS_W       (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cand_if   (bus.master),
        .done      (done),
        .found     (found),
        .exhausted (exhausted)
`ifdef BOMBE_SEARCH_COUNT_EN
        ,
        .tried_cnt (tried_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed observation: {valid, r0, r1, r2, done, found, exhausted}
    function automatic logic [18:0] e(input logic v, input int a, input int b,
                                      input int c, input logic d, input logic f,
                                      input logic x);
        logic [4:0] a5, b5, c5;
        a5 = a[4:0];
        b5 = b[4:0];
        c5 = c[4:0];
        return {v, a5, b5, c5, d, f, x};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.cand_valid, bus.cand_r0, bus.cand_r1, bus.cand_r2, done, found, exhausted};
    endfunction

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        ready;
        logic        rv;
        logic        rm;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[15];

    int          n_cand;
    int          seq_err;
    int          cyc;
    logic [14:0] pos_model;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        bus.cand_ready   = 1'b0;
        bus.result_valid = 1'b0;
        bus.result_match = 1'b0;

        // Reset held with start high, then match at 0, hold, abort cases.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, e(1, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, e(0, 0, 0, 0, 1, 1, 0)};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e(0, 0, 0, 0, 1, 1, 0)};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e(1, 0, 0, 0, 0, 0, 0)};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, e(0, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e(1, 0, 0, 0, 0, 0, 0)};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 0)};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, e(1, 1, 0, 0, 0, 0, 0)};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, e(0, 0, 0, 0, 0, 0, 0)};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e(1, 0, 0, 0, 0, 0, 0)};

        for (int i = 0; i < 15; i++) begin
            reset            = vecs[i].rst_n;
            start            = vecs[i].start;
            bus.cand_ready   = vecs[i].ready;
            bus.result_valid = vecs[i].rv;
            bus.result_match = vecs[i].rm;
            tick();
            check($sformatf("vec%0d", i), {13'd0, obs()}, {13'd0, vecs[i].exp});
        end

        // Backpressure: DUT is in ISSUE at 0,0,0. Reject once to reach 1,0,0.
        bus.cand_ready = 1'b1; bus.result_valid = 1'b0; bus.result_match = 1'b0;
        tick();
        bus.cand_ready = 1'b0; bus.result_valid = 1'b1;
        tick();
        check("bp_enter", {13'd0, obs()}, {13'd0, e(1, 1, 0, 0, 0, 0, 0)});
        for (int i = 0; i < 5; i++) begin
            bus.cand_ready   = 1'b0;
            bus.result_valid = (i == 2);
            bus.result_match = 1'b1;
            tick();
            check($sformatf("bp_hold%0d", i), {13'd0, obs()}, {13'd0, e(1, 1, 0, 0, 0, 0, 0)});
        end
        bus.cand_ready = 1'b1; bus.result_valid = 1'b0; bus.result_match = 1'b0;
        tick();
        bus.cand_ready = 1'b0; bus.result_valid = 1'b1;
        tick();
        check("bp_next", {13'd0, obs()}, {13'd0, e(1, 2, 0, 0, 0, 0, 0)});
        start = 1'b0; bus.result_valid = 1'b0;
        tick();
        check("bp_abort", {13'd0, obs()}, {13'd0, e(0, 0, 0, 0, 0, 0, 0)});

        // Full miss: every candidate rejected, ready and verdict always present.
        start = 1'b1; bus.cand_ready = 1'b1; bus.result_valid = 1'b1; bus.result_match = 1'b0;
        n_cand = 0; seq_err = 0; cyc = 0;
        while (!done && cyc < 40000) begin
            tick();
            cyc++;
            if (bus.cand_valid) begin
                if (bus.cand_r0 != 5'(n_cand % 26) ||
                    bus.cand_r1 != 5'((n_cand / 26) % 26) ||
                    bus.cand_r2 != 5'(n_cand / 676))
                    seq_err++;
                if (n_cand == 25)
                    check("carry_pre_r1", {17'd0, bus.cand_r0, bus.cand_r1, bus.cand_r2}, {17'd0, 5'd25, 5'd0, 5'd0});
                if (n_cand == 26)
                    check("carry_r1", {17'd0, bus.cand_r0, bus.cand_r1, bus.cand_r2}, {17'd0, 5'd0, 5'd1, 5'd0});
                if (n_cand == 675)
                    check("carry_pre_r2", {17'd0, bus.cand_r0, bus.cand_r1, bus.cand_r2}, {17'd0, 5'd25, 5'd25, 5'd0});
                if (n_cand == 676)
                    check("carry_r2", {17'd0, bus.cand_r0, bus.cand_r1, bus.cand_r2}, {17'd0, 5'd0, 5'd0, 5'd1});
                n_cand++;
            end
        end
        check("exh_timeout", (cyc < 40000) ? 32'd1 : 32'd0, 32'd1);
        check("exh_sequence_errors", seq_err, 0);
        check("exh_candidates", n_cand, 17576);
        check("exh_flags", {13'd0, obs()}, {13'd0, e(0, 0, 0, 0, 1, 0, 1)});
`ifdef BOMBE_SEARCH_COUNT_EN
        pos_model = 15'd17576;
        check("exh_tried_cnt", {17'd0, tried_cnt}, {17'd0, pos_model});
`endif
        tick();
        check("exh_hold", {13'd0, obs()}, {13'd0, e(0, 0, 0, 0, 1, 0, 1)});
`ifdef BOMBE_SEARCH_COUNT_EN
        check("exh_tried_hold", {17'd0, tried_cnt}, {17'd0, pos_model});
`endif
        start = 1'b0; bus.result_valid = 1'b0;
        tick();
        check("exh_release", {13'd0, obs()}, {13'd0, e(0, 0, 0, 0, 0, 0, 0)});
`ifdef BOMBE_SEARCH_COUNT_EN
        check("idle_tried_cnt", {17'd0, tried_cnt}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
